// File: rtl/gci_dev_responder_if.sv
// GCI node <-> device bus: request/response data path plus the IRQ handshake.
// Signal names follow the responder's side of the link.
interface gci_dev_responder_if;
  logic        iNODE_REQ;
  logic        oNODE_BUSY;
  logic        iNODE_RW;
  logic [31:0] iNODE_ADDR;
  logic [31:0] iNODE_DATA;
  logic        oNODE_REQ;
  logic        iNODE_BUSY;
  logic [31:0] oNODE_DATA;
  logic        oIRQ_REQ;
  logic        iIRQ_BUSY;
  logic [23:0] oIRQ_DATA;
  logic        iIRQ_ACK;

  modport slave (
    input  iNODE_REQ, iNODE_RW, iNODE_ADDR, iNODE_DATA, iNODE_BUSY, iIRQ_BUSY, iIRQ_ACK,
    output oNODE_BUSY, oNODE_REQ, oNODE_DATA, oIRQ_REQ, oIRQ_DATA
  );

  modport master (
    output iNODE_REQ, iNODE_RW, iNODE_ADDR, iNODE_DATA, iNODE_BUSY, iIRQ_BUSY, iIRQ_ACK,
    input  oNODE_BUSY, oNODE_REQ, oNODE_DATA, oIRQ_REQ, oIRQ_DATA
  );
endinterface

// File: rtl/gci_dev_responder.sv
// Device-side GCI DEV endpoint: info words, read-to-clear IRQ flags, IRQ mask,
// and a small register file, answered after a fixed response latency.
module gci_dev_responder #(
  parameter logic [31:0] MEMSIZE      = 32'h0000_1000,
  parameter logic [7:0]  PRIORITY     = 8'h01,
  parameter int unsigned REG_NUM      = 8,
  parameter logic [7:0]  RESP_LATENCY = 8'd1
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  output logic                 oDEV_VALID,
  input  logic [23:0]          iEVENT,
  gci_dev_responder_if.slave   dev
);

  localparam int unsigned IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_RESP} dstate_t;
  typedef enum logic [1:0] {I_IDLE, I_REQ, I_CLRWAIT} istate_t;

  dstate_t          r_dstate, w_dstate_next;
  istate_t          r_istate, w_istate_next;
  logic             r_dev_valid;
  logic [7:0]       r_lat;
  logic [31:0]      r_rdata;
  logic [23:0]      r_flags;
  logic [23:0]      r_mask;
  logic [31:0]      r_regs [REG_NUM];

  logic [29:0]      w_word;
  logic [29:0]      w_rf_off;
  logic             w_rf_hit;
  logic [IDX_W-1:0] w_rf_idx;
  logic             w_accept;
  logic             w_wr;
  logic             w_rd;
  logic             w_clr;
  logic [31:0]      w_rd_data;
  logic [23:0]      w_pend;
  logic             w_unused_addr;

  assign w_word        = dev.iNODE_ADDR[31:2];
  assign w_unused_addr = ^dev.iNODE_ADDR[1:0];
  assign w_rf_off      = w_word - 30'd4;
  assign w_rf_hit      = (w_word >= 30'd4) && (w_rf_off < 30'(REG_NUM));
  assign w_rf_idx      = w_rf_off[IDX_W-1:0];
  assign w_accept      = dev.iNODE_REQ && (r_dstate == D_IDLE);
  assign w_wr          = w_accept && dev.iNODE_RW;
  assign w_rd          = w_accept && !dev.iNODE_RW;
  assign w_clr         = w_rd && (w_word == 30'd2);
  assign w_pend        = r_flags & r_mask;

  always_comb begin
    w_rd_data = '0;
    if (w_rf_hit) begin
      w_rd_data = r_regs[w_rf_idx];
    end else begin
      case (w_word)
        30'd0:   w_rd_data = MEMSIZE;
        30'd1:   w_rd_data = {24'h0, PRIORITY};
        30'd2:   w_rd_data = {8'h0, r_flags};
        30'd3:   w_rd_data = {8'h0, r_mask};
        default: w_rd_data = '0;
      endcase
    end
  end

  // ---------------- data FSM ----------------
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) r_dstate <= D_IDLE;
    else          r_dstate <= w_dstate_next;
  end

  always_comb begin
    w_dstate_next = r_dstate;
    case (r_dstate)
      D_IDLE: if (w_accept) w_dstate_next = (RESP_LATENCY <= 8'd1) ? D_RESP : D_WAIT;
      // counter reaches 0 on this edge, so the pulse lands RESP_LATENCY edges after accept
      D_WAIT: if (r_lat <= 8'd1) w_dstate_next = D_RESP;
      D_RESP: if (!dev.iNODE_BUSY) w_dstate_next = D_IDLE;
      default: w_dstate_next = D_IDLE;
    endcase
  end

  always_comb begin
    dev.oNODE_BUSY = (r_dstate != D_IDLE);
    dev.oNODE_REQ  = (r_dstate == D_RESP) && !dev.iNODE_BUSY;
    dev.oNODE_DATA = r_rdata;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_lat   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_lat   <= RESP_LATENCY - 8'd1;
        r_rdata <= w_wr ? 32'h0 : w_rd_data;
      end else if (r_dstate == D_WAIT) begin
        r_lat <= r_lat - 8'd1;
      end
    end
  end

  // ---------------- storage ----------------
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_dev_valid <= 1'b0;
      r_flags     <= '0;
      r_mask      <= '1;
    end else begin
      r_dev_valid <= 1'b1;
      // an event arriving on the clear cycle survives the clear
      r_flags     <= (r_flags & ~{24{w_clr}}) | iEVENT;
      if (w_wr && (w_word == 30'd3)) r_mask <= dev.iNODE_DATA[23:0];
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int unsigned i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
    end else if (w_wr && w_rf_hit) begin
      r_regs[w_rf_idx] <= dev.iNODE_DATA;
    end
  end

  assign oDEV_VALID = r_dev_valid;

  // ---------------- IRQ FSM ----------------
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) r_istate <= I_IDLE;
    else          r_istate <= w_istate_next;
  end

  always_comb begin
    w_istate_next = r_istate;
    if (!dev.iIRQ_BUSY) begin
      case (r_istate)
        I_IDLE:    if (w_pend != '0) w_istate_next = I_REQ;
        I_REQ:     if (dev.iIRQ_ACK) w_istate_next = I_CLRWAIT;
        I_CLRWAIT: if (w_clr)        w_istate_next = I_IDLE;
        default:   w_istate_next = I_IDLE;
      endcase
    end
  end

  always_comb begin
    dev.oIRQ_REQ  = (r_istate == I_REQ);
    dev.oIRQ_DATA = (r_istate == I_REQ) ? w_pend : '0;
  end

endmodule

// File: tb/tb_gci_dev_responder.sv
// Randomized + directed bench for gci_dev_responder against a transaction-level model.
module tb_gci_dev_responder;
  localparam int unsigned LAT = 4;
  localparam int unsigned RN  = 8;

  logic        iCLOCK  = 1'b0;
  logic        inRESET = 1'b1;
  logic        oDEV_VALID;
  logic [23:0] iEVENT;

  gci_dev_responder_if dev();

  gci_dev_responder #(
    .MEMSIZE(32'h0000_1000),
    .PRIORITY(8'h01),
    .REG_NUM(RN),
    .RESP_LATENCY(8'(LAT))
  ) u_dut (
    .iCLOCK(iCLOCK),
    .inRESET(inRESET),
    .oDEV_VALID(oDEV_VALID),
    .iEVENT(iEVENT),
    .dev(dev)
  );

  always #5 iCLOCK = ~iCLOCK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] m_regs [RN];
  logic [23:0] m_flags;
  logic [23:0] m_mask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(RN); i++) m_regs[i] = '0;
    m_flags = '0;
    m_mask  = '1;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int unsigned w;
    w = int'(a[31:2]);
    if (w == 0) return 32'h0000_1000;
    if (w == 1) return 32'h0000_0001;
    if (w == 2) return {8'h0, m_flags};
    if (w == 3) return {8'h0, m_mask};
    if (a[31:2] >= 30'd4 && a[31:2] < 30'(4 + RN)) return m_regs[w - 4];
    return 32'h0;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    if (a[31:2] == 30'd3) m_mask = d[23:0];
    else if (a[31:2] >= 30'd4 && a[31:2] < 30'(4 + RN)) m_regs[int'(a[31:2]) - 4] = d;
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic txn(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [23:0] ev,
                     output logic [31:0] rdata, output int unsigned lat);
    dev.iNODE_REQ  = 1'b1;
    dev.iNODE_RW   = rw;
    dev.iNODE_ADDR = a;
    dev.iNODE_DATA = d;
    iEVENT         = ev;
    tick();
    dev.iNODE_REQ = 1'b0;
    iEVENT        = '0;
    lat = 1;
    while (dev.oNODE_REQ !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    rdata = dev.oNODE_DATA;
    tick();
    chk("resp_one_cycle", {31'h0, dev.oNODE_REQ}, 32'h0);
  endtask

  task automatic txn_chk(input string tag, input logic rw, input logic [31:0] a,
                         input logic [31:0] d, input logic [23:0] ev);
    logic [31:0] exp, got;
    int unsigned lat;
    exp = rw ? 32'h0 : m_read(a);
    txn(rw, a, d, ev, got, lat);
    chk({tag, "_data"}, got, exp);
    chk({tag, "_lat"}, lat, LAT);
    if (rw) begin
      m_write(a, d);
      m_flags = m_flags | ev;
    end else if (a[31:2] == 30'd2) begin
      m_flags = ev;
    end else begin
      m_flags = m_flags | ev;
    end
  endtask

  task automatic wait_irq();
    for (int i = 0; i < 10 && dev.oIRQ_REQ !== 1'b1; i++) tick();
  endtask

  task automatic pulse_event(input logic [23:0] ev);
    iEVENT = ev;
    tick();
    iEVENT = '0;
    m_flags = m_flags | ev;
  endtask

  task automatic ack_irq();
    dev.iIRQ_ACK = 1'b1;
    tick();
    dev.iIRQ_ACK = 1'b0;
    chk("irq_drop_after_ack", {31'h0, dev.oIRQ_REQ}, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d, va, vb;
    int unsigned lat, bad, pulses;

    iEVENT         = '0;
    dev.iNODE_REQ  = 1'b0;
    dev.iNODE_RW   = 1'b0;
    dev.iNODE_ADDR = '0;
    dev.iNODE_DATA = '0;
    dev.iNODE_BUSY = 1'b0;
    dev.iIRQ_BUSY  = 1'b0;
    dev.iIRQ_ACK   = 1'b0;
    model_reset();

    #1 inRESET = 1'b0;
    #11;
    chk("rst_dev_valid", {31'h0, oDEV_VALID}, 32'h0);
    chk("rst_busy",      {31'h0, dev.oNODE_BUSY}, 32'h0);
    chk("rst_req",       {31'h0, dev.oNODE_REQ}, 32'h0);
    chk("rst_data",      dev.oNODE_DATA, 32'h0);
    chk("rst_irq",       {31'h0, dev.oIRQ_REQ}, 32'h0);
    chk("rst_irq_data",  {8'h0, dev.oIRQ_DATA}, 32'h0);
    #10 inRESET = 1'b1;
    tick();
    chk("dev_valid", {31'h0, oDEV_VALID}, 32'h1);

    txn_chk("init_memsize", 1'b0, 32'h0, 32'h0, 24'h0);
    txn_chk("init_prio",    1'b0, 32'h4, 32'h0, 24'h0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    a = 32'h10 + 32'(4 * $urandom_range(0, RN - 1));
        2:       a = 32'hC;
        3:       a = 32'(4 * $urandom_range(0, 2));
        default: a = 32'h10 + 32'(4 * RN) + 32'(4 * $urandom_range(0, 1000));
      endcase
      a = a | 32'($urandom_range(0, 3));
      txn_chk("rand", 1'($urandom_range(0, 1)), a, $urandom, 24'h0);
    end
    txn_chk("mask_restore", 1'b1, 32'hC, 32'h00FF_FFFF, 24'h0);
    txn_chk("mask_readback", 1'b0, 32'hC, 32'h0, 24'h0);

    va = $urandom;
    vb = ~va;
    dev.iNODE_REQ  = 1'b1;
    dev.iNODE_RW   = 1'b1;
    dev.iNODE_ADDR = 32'h10;
    dev.iNODE_DATA = va;
    tick();
    dev.iNODE_ADDR = 32'h14;
    dev.iNODE_DATA = vb;
    lat = 1;
    bad = 0;
    while (dev.oNODE_REQ !== 1'b1 && lat < 40) begin
      if (dev.oNODE_BUSY !== 1'b1) bad++;
      tick();
      lat++;
    end
    dev.iNODE_REQ = 1'b0;
    chk("b2b_busy_held", bad, 0);
    chk("b2b_lat", lat, LAT);
    tick();
    m_regs[0] = va;
    txn_chk("b2b_first",  1'b0, 32'h10, 32'h0, 24'h0);
    txn_chk("b2b_second", 1'b0, 32'h14, 32'h0, 24'h0);

    pulse_event(24'h000005);
    wait_irq();
    chk("irq_raise", {31'h0, dev.oIRQ_REQ}, 32'h1);
    chk("irq_data", {8'h0, dev.oIRQ_DATA}, {8'h0, m_flags & m_mask});
    ack_irq();
    txn_chk("flag_read", 1'b0, 32'h8, 32'h0, 24'h0);
    tick();
    chk("irq_idle_after_clear", {31'h0, dev.oIRQ_REQ}, 32'h0);
    txn_chk("flag_cleared", 1'b0, 32'h8, 32'h0, 24'h0);

    pulse_event(24'h000005);
    wait_irq();
    ack_irq();
    txn_chk("race_read", 1'b0, 32'h8, 32'h0, 24'h000002);
    chk("race_reraise", {31'h0, dev.oIRQ_REQ}, 32'h1);
    chk("race_irq_data", {8'h0, dev.oIRQ_DATA}, 32'h2);
    ack_irq();
    txn_chk("race_survivor", 1'b0, 32'h8, 32'h0, 24'h0);

    pulse_event(24'h000001);
    wait_irq();
    txn_chk("mask_zero", 1'b1, 32'hC, 32'h0, 24'h0);
    chk("mask0_req_held", {31'h0, dev.oIRQ_REQ}, 32'h1);
    chk("mask0_data", {8'h0, dev.oIRQ_DATA}, 32'h0);
    ack_irq();
    txn_chk("mask0_flags", 1'b0, 32'h8, 32'h0, 24'h0);
    txn_chk("mask_back", 1'b1, 32'hC, 32'h00FF_FFFF, 24'h0);

    dev.iIRQ_BUSY = 1'b1;
    pulse_event(24'h800008);
    for (int i = 0; i < 4; i++) tick();
    chk("irq_busy_frozen", {31'h0, dev.oIRQ_REQ}, 32'h0);
    dev.iIRQ_BUSY = 1'b0;
    wait_irq();
    chk("irq_after_busy", {8'h0, dev.oIRQ_DATA}, 32'h0080_0008);
    ack_irq();
    txn_chk("irq_busy_flags", 1'b0, 32'h8, 32'h0, 24'h0);

    d = m_read(32'h10);
    dev.iNODE_BUSY = 1'b1;
    dev.iNODE_REQ  = 1'b1;
    dev.iNODE_RW   = 1'b0;
    dev.iNODE_ADDR = 32'h10;
    tick();
    dev.iNODE_REQ = 1'b0;
    bad = 0;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      if (dev.oNODE_REQ !== 1'b0) bad++;
      tick();
    end
    chk("busy_defer", bad, 0);
    dev.iNODE_BUSY = 1'b0;
    #1;
    chk("busy_release_pulse", {31'h0, dev.oNODE_REQ}, 32'h1);
    chk("busy_release_data", dev.oNODE_DATA, d);
    tick();
    chk("busy_single_pulse", {31'h0, dev.oNODE_REQ}, 32'h0);
    chk("busy_back_idle", {31'h0, dev.oNODE_BUSY}, 32'h0);

    dev.iNODE_REQ  = 1'b1;
    dev.iNODE_RW   = 1'b0;
    dev.iNODE_ADDR = 32'h0;
    tick();
    dev.iNODE_REQ = 1'b0;
    tick();
    #2 inRESET = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, dev.oNODE_BUSY}, 32'h0);
    chk("mid_rst_valid", {31'h0, oDEV_VALID}, 32'h0);
    chk("mid_rst_data", dev.oNODE_DATA, 32'h0);
    #3 inRESET = 1'b1;
    model_reset();
    pulses = 0;
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      tick();
      if (dev.oNODE_REQ === 1'b1) pulses++;
    end
    chk("mid_rst_no_pulse", pulses, 0);
    txn_chk("post_rst_reg", 1'b0, 32'h10, 32'h0, 24'h0);
    txn_chk("post_rst_mask", 1'b0, 32'hC, 32'h0, 24'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
